// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out deserializer.
// Holds the FSM state encoding and the counter-width function.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Output handshake bundle of the deserializer.
// Ports: dout (word), dout_valid (word pending), dout_ready (consumer accept).
interface sipo_deser_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/sipo_shreg.sv
// WIDTH-bit shift register with sample enable, sync clear and frame restart.
// Ports: clk, clr, en, first, din in; q (held word), shifted (word after this sample).
module sipo_shreg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             first,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] shifted
);
    localparam logic [WIDTH-2:0] ZERO = '0;

    // "first" drops any partial bits so a restarted frame begins clean.
    always_comb begin
        shifted = q;
        if (MSB_FIRST) begin
            shifted = first ? {ZERO, din} : {q[WIDTH-2:0], din};
        end else begin
            shifted = first ? {din, ZERO} : {din, q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= shifted;
        end
    end
endmodule

// File: rtl/sipo_deser.sv
// Deserializer: rebuilds WIDTH-bit words from bit_en-qualified serial data.
// Ports: clk, rst, bit_en, frame_start, sdi, err_clr in; bus (dout handshake), busy, overrun, frame_err out.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_en,
    input  logic                frame_start,
    input  logic                sdi,
    sipo_deser_if.master        bus,
    output logic                busy,
    output logic                overrun,
    output logic                frame_err,
    input  logic                err_clr
);
    localparam int CW = clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] shifted;
    logic             sample;
    logic             complete;

    assign sample   = bit_en && (state == SHIFT || frame_start);
    assign complete = bit_en && state == SHIFT && !frame_start && cnt == LAST;
    assign busy     = (state == SHIFT);

    sipo_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk     (clk),
        .clr     (rst),
        .en      (sample),
        .first   (frame_start),
        .din     (sdi),
        .q       (word),
        .shifted (shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            overrun        <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            // Clear first so a coincident error event below wins.
            if (err_clr) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end

            if (bit_en) begin
                unique case (state)
                    IDLE: begin
                        if (frame_start) begin
                            state <= SHIFT;
                            cnt   <= CW'(1);
                        end
                    end
                    SHIFT: begin
                        if (frame_start) begin
                            frame_err <= 1'b1;
                            cnt       <= CW'(1);
                        end else if (cnt == LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end

            // The just-finished word may replace one being accepted now.
            if (complete) begin
                if (!bus.dout_valid || bus.dout_ready) begin
                    bus.dout       <= shifted;
                    bus.dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (bus.dout_valid && bus.dout_ready) begin
                bus.dout_valid <= 1'b0;
            end
        end
    end

    logic unused;
    assign unused = ^word;
endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser, MSB_FIRST=1 and MSB_FIRST=0 side by side.
// Scoreboard queues hold expected words; the negedge monitor pops on each transfer.
module tb_sipo_deser;
    logic clk = 1'b0;
    logic rst;
    logic bit_en;
    logic frame_start;
    logic sdi;
    logic err_clr;
    logic ready;
    logic busy_m, ovr_m, ferr_m;
    logic busy_l, ovr_l, ferr_l;

    sipo_deser_if #(.WIDTH(4)) ifm ();
    sipo_deser_if #(.WIDTH(4)) ifl ();

    assign ifm.dout_ready = ready;
    assign ifl.dout_ready = ready;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk         (clk),
        .rst         (rst),
        .bit_en      (bit_en),
        .frame_start (frame_start),
        .sdi         (sdi),
        .bus         (ifm),
        .busy        (busy_m),
        .overrun     (ovr_m),
        .frame_err   (ferr_m),
        .err_clr     (err_clr)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk         (clk),
        .rst         (rst),
        .bit_en      (bit_en),
        .frame_start (frame_start),
        .sdi         (sdi),
        .bus         (ifl),
        .busy        (busy_l),
        .overrun     (ovr_l),
        .frame_err   (ferr_l),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [3:0] q_m[$];
    logic [3:0] q_l[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive_bit(input logic fs, input logic b,
                             input logic rdy, input logic clr);
        bit_en      = 1'b1;
        frame_start = fs;
        sdi         = b;
        ready       = rdy;
        err_clr     = clr;
        step();
        bit_en      = 1'b0;
        frame_start = 1'b0;
        sdi         = 1'b0;
        ready       = 1'b0;
        err_clr     = 1'b0;
    endtask

    // Sends w[3] first; the MSB-first DUT rebuilds w, the other rev4(w).
    task automatic send_word(input logic [3:0] w, input bit push,
                             input logic rdy_last, input logic clr_last,
                             input bit tmg);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                if (tmg) check("valid_early", ifm.dout_valid, 0);
                if (push) begin
                    q_m.push_back(w);
                    q_l.push_back(rev4(w));
                end
                drive_bit(1'b0, w[0], rdy_last, clr_last);
                check("busy_end", busy_m, 0);
            end else begin
                drive_bit(i == 0, w[3-i], 1'b0, 1'b0);
                check("busy_mid", busy_m, 1);
                idle(7);
            end
        end
    endtask

    task automatic consume();
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("valid_drop", ifm.dout_valid, 0);
        check("valid_drop_l", ifl.dout_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ifm.dout_valid && ready) begin
                if (q_m.size() == 0) check("sb_m_extra", q_m.size(), 1);
                else check("sb_m", ifm.dout, q_m.pop_front());
            end
            if (ifl.dout_valid && ready) begin
                if (q_l.size() == 0) check("sb_l_extra", q_l.size(), 1);
                else check("sb_l", ifl.dout, q_l.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bit_en = 1'b0; frame_start = 1'b0;
        sdi = 1'b0; err_clr = 1'b0; ready = 1'b0;
        idle(3);
        rst = 1'b0;
        step();
        check("rst_dout", ifm.dout, 0);
        check("rst_valid", ifm.dout_valid, 0);
        check("rst_busy", busy_m, 0);
        check("rst_ovr", ovr_m, 0);
        check("rst_ferr", ferr_m, 0);

        // Single word 1,0,1,1 with latency check.
        send_word(4'b1011, 1, 1'b0, 1'b0, 1);
        check("w1_valid", ifm.dout_valid, 1);
        check("w1_dout_m", ifm.dout, 4'b1011);
        check("w1_dout_l", ifl.dout, 4'b1101);
        idle(3);
        consume();
        check("w1_hold", ifm.dout, 4'b1011);
        idle(4);

        // Overrun with ready low; err_clr coincides with the drop.
        send_word(4'hA, 1, 1'b0, 1'b0, 1);
        idle(7);
        send_word(4'h5, 0, 1'b0, 1'b1, 0);
        check("ovr_set", ovr_m, 1);
        check("ovr_set_l", ovr_l, 1);
        check("ovr_keep", ifm.dout, 4'hA);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovr_clr", ovr_m, 0);
        consume();
        idle(4);

        // Accept and completion on the same edge.
        send_word(4'h3, 1, 1'b0, 1'b0, 1);
        idle(7);
        send_word(4'hC, 1, 1'b1, 1'b0, 0);
        check("b2b_valid", ifm.dout_valid, 1);
        check("b2b_dout", ifm.dout, 4'hC);
        check("b2b_ovr", ovr_m, 0);
        consume();
        idle(4);

        // Abort after two bits, then full word 6.
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        idle(7);
        drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
        idle(7);
        send_word(4'h6, 1, 1'b0, 1'b0, 1);
        check("abort_ferr", ferr_m, 1);
        check("abort_dout", ifm.dout, 4'h6);
        check("abort_dout_l", ifl.dout, 4'h6);
        consume();
        idle(4);

        // Reset mid-frame while a word is pending.
        send_word(4'hF, 1, 1'b0, 1'b0, 1);
        idle(7);
        drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
        idle(7);
        drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
        idle(7);
        drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        q_m.delete();
        q_l.delete();
        step();
        rst = 1'b0;
        check("mrst_dout", ifm.dout, 0);
        check("mrst_valid", ifm.dout_valid, 0);
        check("mrst_busy", busy_m, 0);
        check("mrst_ferr", ferr_m, 0);
        check("mrst_valid_l", ifl.dout_valid, 0);
        idle(3);
        send_word(4'h9, 1, 1'b0, 1'b0, 1);
        check("post_dout", ifm.dout, 4'h9);
        consume();
        idle(2);

        check("sb_m_drained", q_m.size(), 0);
        check("sb_l_drained", q_l.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Serial-in parallel-out deserializer. It sits directly downstream of the 4-bit PISO shifter and rebuilds WIDTH-bit words from its serial output, sampling one bit per bit_en strobe from the shared slow-tick divider. Completed words pass to a double-buffered output register with a valid/ready handshake. Overrun and framing errors are reported through sticky flags.

Parameters:
WIDTH, 4, bits per word; legal range 2..16.
MSB_FIRST, 1, 1 means the first received bit lands in dout[WIDTH-1]; 0 means it lands in dout[0].

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
bit_en  input  1  one-clk strobe; sdi is sampled only in cycles where bit_en=1
frame_start  input  1  qualified by bit_en; marks the current sdi bit as the first bit of a word
sdi  input  1  serial data in
dout  output  WIDTH  last completed word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout on the edge where dout_valid=1 and dout_ready=1
busy  output  1  high while a word is partially received (state SHIFT)
overrun  output  1  sticky; a completed word was dropped
frame_err  output  1  sticky; a frame was aborted by a new frame_start
err_clr  input  1  one-clk pulse that clears overrun and frame_err

Behaviour:
- Reset on clk edge with rst=1: state=IDLE, bit counter=0, shift register=0, dout=0, dout_valid=0, busy=0, overrun=0, frame_err=0. rst overrides all other inputs. Reset mid-frame discards partial bits and clears dout_valid.
- States:
  - IDLE: bit_en=0, or bit_en=1 with frame_start=0, does nothing. bit_en=1 with frame_start=1 captures sdi as bit 0, sets cnt=1, goes to SHIFT.
  - SHIFT: bit_en=1 with frame_start=0 captures sdi and increments cnt. When this capture is bit WIDTH-1, the word completes (see below), cnt becomes 0 and the state returns to IDLE.
  - SHIFT, bit_en=1 with frame_start=1: sets frame_err, discards partial bits, captures sdi as bit 0 of a new frame, sets cnt=1, stays in SHIFT.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit enters at LSB; after WIDTH bits the first bit is at WIDTH-1.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
- Completion happens on the clk edge that samples the last bit. The assembled word, including that last bit, is evaluated the same edge:
  - dout_valid=0, or dout_valid=1 with dout_ready=1: dout gets the word, dout_valid=1 on the next cycle. Latency is 1 clk from the last bit_en cycle to dout_valid. A simultaneous accept plus new completion keeps dout_valid=1 with the new word; this is not an overrun.
  - dout_valid=1 with dout_ready=0: the new word is dropped, overrun=1, dout keeps the old word.
- Handshake:
  - dout_valid=1 and dout_ready=1 with no completion that cycle: dout_valid falls to 0 next cycle. dout is not cleared.
  - dout is stable while dout_valid=1 and no transfer occurs.
  - dout_ready is ignored while dout_valid=0.
- Sticky flags:
  - err_clr clears overrun and frame_err.
  - If err_clr coincides with a new error event, the set wins and the flag reads 1.
- Cycles with bit_en=0 never change the shift register, cnt or state.
- busy = (state==SHIFT).
- Receiving the next word in SHIFT while dout_valid=1 is legal; this is the purpose of the double buffer.
- cnt width is clog2(WIDTH)+1. cnt never exceeds WIDTH-1 at rest.

Decomposition:
- Shared package sipo_pkg:
  - state typedef: enum of IDLE and SHIFT, 1 bit.
  - function clog2 for the counter width.
- One natural sub-module, sipo_shreg: a WIDTH-bit shift register with sample-enable and clear, MSB_FIRST-selectable.
- The FSM, counter, output register and flags stay in the top level.

Test Plan:
- Reset then single word, WIDTH=4, MSB_FIRST=1: bit_en every 8 clks, frame_start with the first bit, sdi sequence 1,0,1,1 -> dout=4'b1011 and dout_valid=1 exactly 1 clk after the 4th bit_en. busy is high from the 1st to the 4th sample.
- Same stimulus with MSB_FIRST=0 -> dout=4'b1101.
- Back-to-back words 4'hA then 4'h5 with dout_ready held 0 -> dout stays 4'hA, overrun=1 after the 8th bit. err_clr pulse -> overrun=0.
- Back-to-back words 4'h3 then 4'hC, with dout_ready=1 pulsed in the same cycle the second word completes -> dout=4'hC, dout_valid stays 1, overrun=0.
- Abort: frame_start after 2 bits, then full word 4'h6 -> frame_err=1, dout=4'h6. No word is produced from the aborted bits.
- rst asserted after 3 bits with dout_valid=1 -> all outputs return to 0 the next cycle. A following full word 4'h9 is received correctly.
